// File: rtl/systolic_nbody_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_nbody_pkg
// Purpose  : Shared types and constants for the 2x2 systolic n-body force
//            pipeline (feeder, tag delay line, array, accumulator).
// Contents : default widths/latency, feeder FSM state enum, block-pair tag
//            struct, gravitational constant and softening epsilon.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_nbody_pkg;

  localparam int  FEED_BLK_W     = 8;
  localparam int  FEED_ADDR_W    = 9;
  localparam int  FEED_ARRAY_LAT = 2;

  localparam real G_CONST   = 6.67e-11;
  localparam real DENOM_EPS = 1e-8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LAND  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_SKEW  = 3'd4,
    ST_DRAIN = 3'd5
  } feeder_state_t;

  typedef struct packed {
    logic [FEED_BLK_W-1:0] blk_i;
    logic [FEED_BLK_W-1:0] blk_j;
    logic                  diag;
  } blk_tag_t;

endpackage
`default_nettype wire

// File: rtl/systolic_2x2_block_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_2x2_block_feeder_if
// Purpose  : Body-memory read port between the block feeder and body memory.
// Ports    : rd_en   - read strobe (feeder -> memory)
//            rd_addr - body index (feeder -> memory)
//            rd_q    - position, valid 1 cycle after rd_en (memory -> feeder)
//            rd_m    - mass, valid 1 cycle after rd_en (memory -> feeder)
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_2x2_block_feeder_if #(
  parameter int ADDR_W = 9
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  real               rd_q;
  real               rd_m;

  modport master (output rd_en, output rd_addr, input rd_q, input rd_m);
  modport slave  (input rd_en, input rd_addr, output rd_q, output rd_m);
endinterface
`default_nettype wire

// File: rtl/systolic_2x2_tag_delay.sv
`default_nettype none
// ============================================================================
// Module   : systolic_2x2_tag_delay
// Purpose  : ARRAY_LAT-deep shift register carrying {valid, block tag} from
//            the issue cycle to the array's index-0 result cycle, plus one
//            extra valid stage for the index-1 result.
// Ports    : clk, rst_n        - clock, async active-low reset
//            in_valid, in_tag  - issue strobe and tag (valid in cycle c)
//            out_valid_0/tag   - valid in cycle c+ARRAY_LAT
//            out_valid_1       - valid in cycle c+ARRAY_LAT+1
// Revision : 1.0 - initial release
// ============================================================================
module systolic_2x2_tag_delay
  import systolic_nbody_pkg::*;
#(
  parameter int ARRAY_LAT = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  input  blk_tag_t in_tag,
  output logic     out_valid_0,
  output blk_tag_t out_tag,
  output logic     out_valid_1
);

  logic [ARRAY_LAT-1:0] vld_q;
  blk_tag_t             tag_q [ARRAY_LAT];
  logic                 v1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      v1_q  <= 1'b0;
      for (int k = 0; k < ARRAY_LAT; k++) tag_q[k] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      tag_q[0] <= in_tag;
      for (int k = 1; k < ARRAY_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      v1_q <= vld_q[ARRAY_LAT-1];
    end
  end

  assign out_valid_0 = vld_q[ARRAY_LAT-1];
  assign out_tag     = tag_q[ARRAY_LAT-1];
  assign out_valid_1 = v1_q;

endmodule
`default_nettype wire

// File: rtl/systolic_2x2_block_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_2x2_block_feeder
// Purpose  : Input-side sequencer of the 2x2 systolic force array. Walks the
//            upper-triangular block pairs (I,J), J>=I, row-major; fetches the
//            four bodies of each pair, drives the array with a one-cycle skew
//            between index 0 and index 1, and emits result strobes and tags
//            aligned to the array outputs.
// Ports    : clk, rst_n           - clock, async active-low reset
//            start, n_blocks      - pass request and block count (IDLE only)
//            busy, done           - pass in progress / completion pulse
//            col_ready            - downstream can take the next pair
//            mem (master)         - body memory read port
//            q_*/m_*              - array position/mass inputs
//            pr_*/pd_*            - accumulation seeds (always 0.0)
//            res_valid_0/1        - array index-0/index-1 outputs valid
//            res_blk_i/j,res_diag - pair tag, aligned with res_valid_0
// Revision : 1.0 - initial release
// ============================================================================
module systolic_2x2_block_feeder
  import systolic_nbody_pkg::*;
#(
  parameter int BLK_W     = FEED_BLK_W,
  parameter int ADDR_W    = FEED_ADDR_W,
  parameter int ARRAY_LAT = FEED_ARRAY_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BLK_W-1:0] n_blocks,
  output logic             busy,
  output logic             done,
  input  logic             col_ready,
  systolic_2x2_block_feeder_if.master mem,
  output real              q_0i, q_1i, q_0j, q_1j,
  output real              m_0i, m_1i, m_0j, m_1j,
  output real              pr_0, pr_1, pd_0, pd_1,
  output logic             res_valid_0,
  output logic             res_valid_1,
  output logic [BLK_W-1:0] res_blk_i,
  output logic [BLK_W-1:0] res_blk_j,
  output logic             res_diag
);

  feeder_state_t    state_q, state_d;
  logic [BLK_W-1:0] n_q, n_d, bi_q, bi_d, bj_q, bj_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [7:0]       dcnt_q, dcnt_d;

  // Fetched bodies of the current pair
  real  i0q_q, i0m_q, i1q_q, i1m_q, j0q_q, j0m_q, j1q_q, j1m_q;
  logic cap_v_q;
  logic [1:0] cap_sel_q;

  // Registered outputs and their next values
  logic busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, iss_q, iss_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  blk_tag_t tag_q, tag_d;
  real q0i_q, q0j_q, q1i_q, q1j_q, m0i_q, m0j_q, m1i_q, m1j_q;
  real q0i_d, q0j_d, q1i_d, q1j_d, m0i_d, m0j_d, m1i_d, m1j_d;
  logic [BLK_W-1:0] blk_sel;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      bi_q    <= '0;
      bj_q    <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      bi_q    <= bi_d;
      bj_q    <= bj_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    bi_d    = bi_q;
    bj_d    = bj_q;
    fcnt_d  = fcnt_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (n_blocks != '0)) begin
          state_d = ST_FETCH;
          n_d     = n_blocks;
          bi_d    = '0;
          bj_d    = '0;
          fcnt_d  = '0;
        end
      end
      ST_FETCH: begin
        // fcnt wraps back to 0 after the 4th read, ready for the next pair
        fcnt_d = fcnt_q + 2'd1;
        if (fcnt_q == 2'd3) state_d = ST_LAND;
      end
      ST_LAND:  state_d = ST_ISSUE;
      ST_ISSUE: if (col_ready) state_d = ST_SKEW;
      ST_SKEW: begin
        if (bj_q == n_q - 1'b1) begin
          bi_d = bi_q + 1'b1;
          bj_d = bi_q + 1'b1;
        end else begin
          bj_d = bj_q + 1'b1;
        end
        if (bi_d == n_q) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // DRAIN starts the cycle after issue; the last res_valid_1 lands
        // ARRAY_LAT cycles later
        dcnt_d = dcnt_q + 8'd1;
        if (dcnt_q == 8'(ARRAY_LAT)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    done_d  = ((state_q == ST_IDLE) && start && (n_blocks == '0)) ||
              ((state_q == ST_DRAIN) && (state_d == ST_IDLE));
    rd_en_d = (state_d == ST_FETCH);
    blk_sel = fcnt_d[1] ? bj_d : bi_d;
    rd_addr_d = rd_en_d ? ((ADDR_W'(blk_sel) << 1) | ADDR_W'(fcnt_d[0])) : '0;
    iss_d   = (state_q == ST_ISSUE) && col_ready;
    tag_d.blk_i = FEED_BLK_W'(bi_q);
    tag_d.blk_j = FEED_BLK_W'(bj_q);
    tag_d.diag  = (bi_q == bj_q);
    // Index 0 is driven the cycle after issue is accepted, index 1 one later;
    // every other cycle the array sees zero-mass bodies
    q0i_d = iss_d ? i0q_q : 0.0;
    m0i_d = iss_d ? i0m_q : 0.0;
    q0j_d = iss_d ? j0q_q : 0.0;
    m0j_d = iss_d ? j0m_q : 0.0;
    q1i_d = (state_q == ST_SKEW) ? i1q_q : 0.0;
    m1i_d = (state_q == ST_SKEW) ? i1m_q : 0.0;
    q1j_d = (state_q == ST_SKEW) ? j1q_q : 0.0;
    m1j_d = (state_q == ST_SKEW) ? j1m_q : 0.0;
  end

  // Output registers and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0; done_q <= 1'b0; rd_en_q <= 1'b0; iss_q <= 1'b0;
      rd_addr_q <= '0; tag_q <= '0;
      q0i_q <= 0.0; m0i_q <= 0.0; q0j_q <= 0.0; m0j_q <= 0.0;
      q1i_q <= 0.0; m1i_q <= 0.0; q1j_q <= 0.0; m1j_q <= 0.0;
      i0q_q <= 0.0; i0m_q <= 0.0; i1q_q <= 0.0; i1m_q <= 0.0;
      j0q_q <= 0.0; j0m_q <= 0.0; j1q_q <= 0.0; j1m_q <= 0.0;
      cap_v_q <= 1'b0; cap_sel_q <= '0;
    end else begin
      busy_q <= busy_d; done_q <= done_d; rd_en_q <= rd_en_d; iss_q <= iss_d;
      rd_addr_q <= rd_addr_d; tag_q <= tag_d;
      q0i_q <= q0i_d; m0i_q <= m0i_d; q0j_q <= q0j_d; m0j_q <= m0j_d;
      q1i_q <= q1i_d; m1i_q <= m1i_d; q1j_q <= q1j_d; m1j_q <= m1j_d;
      // Memory answers one cycle after the strobe; remember which slot it fills
      cap_v_q   <= (state_q == ST_FETCH);
      cap_sel_q <= fcnt_q;
      if (cap_v_q) begin
        unique case (cap_sel_q)
          2'd0: begin i0q_q <= mem.rd_q; i0m_q <= mem.rd_m; end
          2'd1: begin i1q_q <= mem.rd_q; i1m_q <= mem.rd_m; end
          2'd2: begin j0q_q <= mem.rd_q; j0m_q <= mem.rd_m; end
          default: begin j1q_q <= mem.rd_q; j1m_q <= mem.rd_m; end
        endcase
      end
    end
  end

  blk_tag_t dly_tag;

  systolic_2x2_tag_delay #(
    .ARRAY_LAT (ARRAY_LAT)
  ) u_tag_delay (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (iss_q),
    .in_tag      (tag_q),
    .out_valid_0 (res_valid_0),
    .out_tag     (dly_tag),
    .out_valid_1 (res_valid_1)
  );

  assign res_blk_i   = BLK_W'(dly_tag.blk_i);
  assign res_blk_j   = BLK_W'(dly_tag.blk_j);
  assign res_diag    = dly_tag.diag;
  assign busy        = busy_q;
  assign done        = done_q;
  assign mem.rd_en   = rd_en_q;
  assign mem.rd_addr = rd_addr_q;
  assign q_0i = q0i_q; assign m_0i = m0i_q; assign q_0j = q0j_q; assign m_0j = m0j_q;
  assign q_1i = q1i_q; assign m_1i = m1i_q; assign q_1j = q1j_q; assign m_1j = m1j_q;
  assign pr_0 = 0.0; assign pr_1 = 0.0; assign pd_0 = 0.0; assign pd_1 = 0.0;

endmodule
`default_nettype wire
